// File: rtl/issue_queue_int.sv
// ----------------------------------------------------------------------------
// issue_queue_int -- collapsing integer issue queue
//
// Entries sit at indices 0..count-1, and index 0 holds the oldest entry.
// Each cycle the queue selects the oldest entry whose two source operands are
// both ready. When the integer pipe accepts that entry, it is removed and every
// younger entry moves down one slot. A dispatch group is written behind the
// entries that remain after this compaction.
//
// Ports
//   clock         sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   flush         synchronous flush; it overrides enqueue and issue
//   uop_in        dispatch group, valid slots contiguous from slot 0
//   rs1_rdy_in    busy-table readiness of rs1, one bit per slot
//   rs2_rdy_in    busy-table readiness of rs2, one bit per slot
//   in_ready      a full dispatch group fits this cycle
//   wakeup_valid  writeback tag broadcast valids
//   wakeup_tag    writeback tag broadcast tags
//   uop_out       oldest ready entry; all-zero when there is none
//   issue_ready   integer pipe accepts uop_out
//   free_count    number of empty entries
//   perf_issue_cnt, perf_full_cnt   only exist when IQ_PERF_CNT_EN is defined
//
// Build options
//   IQ_PERF_CNT_EN  adds the perf_issue_cnt and perf_full_cnt counters
//   DISPATCH_WIDTH  dispatch group width (default 4)
//
// Sizing rules
//   IQ_SIZE must be a power of two and at least 2*DISPATCH_WIDTH.
//   PREG_W must equal issue_queue_int_pkg::PKG_PREG_W.
// ----------------------------------------------------------------------------
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package issue_queue_int_pkg;
  localparam int PKG_PREG_W = 6;

  typedef struct packed {
    logic                  valid;
    logic [6:0]            opcode;
    logic [PKG_PREG_W-1:0] rd_preg;
    logic [PKG_PREG_W-1:0] rs1_preg;
    logic [PKG_PREG_W-1:0] rs2_preg;
  } micro_op_t;
endpackage

module issue_queue_int #(
  parameter int IQ_SIZE      = 16,
  parameter int WAKEUP_WIDTH = 4,
  parameter int PREG_W       = issue_queue_int_pkg::PKG_PREG_W
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            flush,
  input  issue_queue_int_pkg::micro_op_t [`DISPATCH_WIDTH-1:0] uop_in,
  input  logic [`DISPATCH_WIDTH-1:0]                      rs1_rdy_in,
  input  logic [`DISPATCH_WIDTH-1:0]                      rs2_rdy_in,
  output logic                                            in_ready,
  input  logic [WAKEUP_WIDTH-1:0]                         wakeup_valid,
  input  logic [WAKEUP_WIDTH-1:0][PREG_W-1:0]             wakeup_tag,
  output issue_queue_int_pkg::micro_op_t                  uop_out,
  input  logic                                            issue_ready,
  output logic [$clog2(IQ_SIZE):0]                        free_count
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]                                     perf_issue_cnt,
  output logic [31:0]                                     perf_full_cnt
`endif
);

  localparam int DW    = `DISPATCH_WIDTH;
  localparam int IDX_W = $clog2(IQ_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef issue_queue_int_pkg::micro_op_t uop_t;

  // The valid bit inside each stored uop is the entry's valid bit.
  uop_t               ent_q [IQ_SIZE];
  logic [IQ_SIZE-1:0] rs1_rdy_q;
  logic [IQ_SIZE-1:0] rs2_rdy_q;
  logic [CNT_W-1:0]   cnt_q;

  uop_t               ent_d [IQ_SIZE];
  logic [IQ_SIZE-1:0] rs1_rdy_d;
  logic [IQ_SIZE-1:0] rs2_rdy_d;
  logic [CNT_W-1:0]   cnt_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               issue_fire;

  // Tag 0 is the hardwired zero register, so it is always ready.
  function automatic logic wake_hit(
    input logic [PREG_W-1:0]                     tag,
    input logic [WAKEUP_WIDTH-1:0]               vld,
    input logic [WAKEUP_WIDTH-1:0][PREG_W-1:0]   tags
  );
    logic hit;
    hit = (tag == '0);
    for (int k = 0; k < WAKEUP_WIDTH; k++)
      if (vld[k] && (tags[k] == tag)) hit = 1'b1;
    return hit;
  endfunction

  assign free_count = CNT_W'(IQ_SIZE) - cnt_q;
  assign in_ready   = (free_count >= CNT_W'(DW));

  // The select uses only registered ready bits. A wakeup seen this cycle
  // therefore cannot make its entry selectable until the next cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = IQ_SIZE - 1; i >= 0; i--) begin
      if (ent_q[i].valid && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign uop_out    = sel_found ? ent_q[sel_idx] : '0;
  assign issue_fire = sel_found && issue_ready && !flush;

  always_comb begin
    int src;
    int pos;
    for (int i = 0; i < IQ_SIZE; i++) ent_d[i] = '0;
    rs1_rdy_d = '0;
    rs2_rdy_d = '0;
    cnt_d     = '0;
    src       = 0;
    pos       = 0;

    // Collapse over the issued entry and apply this cycle's wakeups.
    for (int i = 0; i < IQ_SIZE; i++) begin
      src = (issue_fire && (i >= int'(sel_idx))) ? i + 1 : i;
      if (src < IQ_SIZE) begin
        ent_d[i]     = ent_q[IDX_W'(src)];
        rs1_rdy_d[i] = ent_q[IDX_W'(src)].valid &
                       (rs1_rdy_q[IDX_W'(src)] |
                        wake_hit(ent_q[IDX_W'(src)].rs1_preg, wakeup_valid, wakeup_tag));
        rs2_rdy_d[i] = ent_q[IDX_W'(src)].valid &
                       (rs2_rdy_q[IDX_W'(src)] |
                        wake_hit(ent_q[IDX_W'(src)].rs2_preg, wakeup_valid, wakeup_tag));
      end
    end

    // New uops are appended behind the entries that survive, in slot order.
    // When in_ready is 1 the group always fits, so pos never overruns.
    pos = int'(cnt_q - CNT_W'(issue_fire));
    if (in_ready) begin
      for (int j = 0; j < DW; j++) begin
        if (uop_in[j].valid && (pos < IQ_SIZE)) begin
          ent_d[IDX_W'(pos)]     = uop_in[j];
          rs1_rdy_d[IDX_W'(pos)] = rs1_rdy_in[j] |
                                   wake_hit(uop_in[j].rs1_preg, wakeup_valid, wakeup_tag);
          rs2_rdy_d[IDX_W'(pos)] = rs2_rdy_in[j] |
                                   wake_hit(uop_in[j].rs2_preg, wakeup_valid, wakeup_tag);
          pos = pos + 1;
        end
      end
    end
    cnt_d = CNT_W'(pos);

    if (flush) begin
      for (int i = 0; i < IQ_SIZE; i++) ent_d[i] = '0;
      rs1_rdy_d = '0;
      rs2_rdy_d = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < IQ_SIZE; i++) ent_q[i] <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < IQ_SIZE; i++) ent_q[i] <= ent_d[i];
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef IQ_PERF_CNT_EN
  // A flush does not clear these counters; only reset does.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue_fire) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (!in_ready)  perf_full_cnt  <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_int.sv
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

module tb_issue_queue_int;
  localparam int DW = `DISPATCH_WIDTH;

  typedef issue_queue_int_pkg::micro_op_t uop_t;

  logic                clock;
  logic                reset_n;
  logic                flush;
  uop_t [DW-1:0]       uop_in;
  logic [DW-1:0]       rs1_rdy_in;
  logic [DW-1:0]       rs2_rdy_in;
  logic                in_ready;
  logic [3:0]          wakeup_valid;
  logic [3:0][5:0]     wakeup_tag;
  uop_t                uop_out;
  logic                issue_ready;
  logic [4:0]          free_count;
`ifdef IQ_PERF_CNT_EN
  logic [31:0]         perf_issue_cnt;
  logic [31:0]         perf_full_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  issue_queue_int dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .uop_in       (uop_in),
    .rs1_rdy_in   (rs1_rdy_in),
    .rs2_rdy_in   (rs2_rdy_in),
    .in_ready     (in_ready),
    .wakeup_valid (wakeup_valid),
    .wakeup_tag   (wakeup_tag),
    .uop_out      (uop_out),
    .issue_ready  (issue_ready),
    .free_count   (free_count)
`ifdef IQ_PERF_CNT_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_full_cnt  (perf_full_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    uop_in     = '0;
    rs1_rdy_in = '0;
    rs2_rdy_in = '0;
  endtask

  task automatic set_slot(input int s, input int op, input int r1, input int r2,
                          input logic rdy1, input logic rdy2);
    uop_t u;
    u          = '0;
    u.valid    = 1'b1;
    u.opcode   = 7'(op);
    u.rd_preg  = 6'(op);
    u.rs1_preg = 6'(r1);
    u.rs2_preg = 6'(r2);
    uop_in[s]     = u;
    rs1_rdy_in[s] = rdy1;
    rs2_rdy_in[s] = rdy2;
  endtask

  // Drive n contiguous uops whose operands are all ready, with opcodes op0, op0+1, ...
  task automatic grp(input int n, input int op0);
    clr_in();
    for (int j = 0; j < n; j++) set_slot(j, op0 + j, 10 + j, 20 + j, 1'b1, 1'b1);
  endtask

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    issue_ready  = 1'b0;
    wakeup_valid = '0;
    wakeup_tag   = '0;
    clr_in();

    // Reset takes effect with no clock edge.
    #3;
    chk("rst_free", 32'(free_count), 16);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_uop_out", 32'(uop_out), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Four ready uops issue in order, one per cycle, starting the cycle after enqueue.
    grp(4, 1);
    issue_ready = 1'b1;
    step();
    clr_in();
    chk("e4_free_after_enq", 32'(free_count), 12);
    for (int k = 1; k <= 4; k++) begin
      chk("e4_order_op", 32'(uop_out.opcode), 32'(k));
      chk("e4_valid", 32'(uop_out.valid), 1);
      step();
    end
    chk("e4_empty_valid", 32'(uop_out.valid), 0);
    chk("e4_free_back", 32'(free_count), 16);

    // Issue and enqueue in the same cycle; the new uops land after compaction.
    issue_ready = 1'b0;
    grp(1, 60);
    step();
    issue_ready = 1'b1;
    grp(2, 61);
    step();
    clr_in();
    chk("iss_enq_op", 32'(uop_out.opcode), 61);
    chk("iss_enq_free", 32'(free_count), 14);
    step();
    chk("iss_enq_op2", 32'(uop_out.opcode), 62);
    step();
    chk("iss_enq_free_end", 32'(free_count), 16);

    // The younger ready uop issues first. The waiting uop wakes one cycle after its tag.
    issue_ready = 1'b0;
    clr_in();
    set_slot(0, 5, 5, 0, 1'b0, 1'b0);
    set_slot(1, 6, 7, 8, 1'b1, 1'b1);
    step();
    clr_in();
    chk("wk_younger_first", 32'(uop_out.opcode), 6);
    wakeup_tag[0] = 6'd5;
    issue_ready   = 1'b1;
    step();
    chk("wk_invalid_tag_ignored", 32'(uop_out.valid), 0);
    chk("wk_free_after_issue", 32'(free_count), 15);
    wakeup_tag[0]   = 6'd0;
    wakeup_valid[2] = 1'b1;
    wakeup_tag[2]   = 6'd5;
    #1;
    chk("wk_no_same_cycle", 32'(uop_out.valid), 0);
    step();
    wakeup_valid = '0;
    wakeup_tag   = '0;
    chk("wk_next_cycle_valid", 32'(uop_out.valid), 1);
    chk("wk_next_cycle_op", 32'(uop_out.opcode), 5);
    step();
    chk("wk_drain_free", 32'(free_count), 16);

    // Fill to free_count=3, drop a group, hold for 3 cycles, then issue once.
    issue_ready = 1'b0;
    grp(4, 16); step();
    grp(4, 20); step();
    grp(4, 24); step();
    chk("fill_free4", 32'(free_count), 4);
    chk("fill_rdy_at4", 32'(in_ready), 1);
    grp(1, 28); step();
    chk("fill_free3", 32'(free_count), 3);
    chk("fill_rdy_at3", 32'(in_ready), 0);
    grp(4, 40); step();
    clr_in();
    chk("drop_free", 32'(free_count), 3);
    for (int k = 0; k < 3; k++) begin
      chk("hold_op", 32'(uop_out.opcode), 16);
      chk("hold_free", 32'(free_count), 3);
      step();
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("one_iss_free", 32'(free_count), 4);
    chk("one_iss_rdy", 32'(in_ready), 1);
    chk("one_iss_next_op", 32'(uop_out.opcode), 17);
    grp(4, 44); step();
    chk("full_free", 32'(free_count), 0);
    chk("full_rdy", 32'(in_ready), 0);
    grp(4, 50); step();
    clr_in();
    chk("full_drop_free", 32'(free_count), 0);

    // Flush clears the queue and overrides enqueue and issue in the same cycle.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_full_free", 32'(free_count), 16);
    chk("flush_full_valid", 32'(uop_out.valid), 0);
    grp(4, 70); step();
    grp(4, 74); step();
    grp(2, 78); step();
    chk("pre_flush_free", 32'(free_count), 6);
    grp(4, 80);
    flush       = 1'b1;
    issue_ready = 1'b1;
    step();
    flush       = 1'b0;
    issue_ready = 1'b0;
    clr_in();
    chk("flush_free", 32'(free_count), 16);
    chk("flush_valid", 32'(uop_out.valid), 0);
    step();
    chk("flush_stays_empty", 32'(free_count), 16);

    // A wakeup on the enqueue cycle counts for the enqueued uop.
    clr_in();
    set_slot(0, 90, 3, 9, 1'b1, 1'b0);
    wakeup_valid[1] = 1'b1;
    wakeup_tag[1]   = 6'd9;
    step();
    clr_in();
    wakeup_valid = '0;
    wakeup_tag   = '0;
    chk("enq_wake_valid", 32'(uop_out.valid), 1);
    chk("enq_wake_op", 32'(uop_out.opcode), 90);
`ifdef IQ_PERF_CNT_EN
    chk("perf_before", perf_issue_cnt, 10);
`endif
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    chk("enq_wake_issued", 32'(free_count), 16);
`ifdef IQ_PERF_CNT_EN
    chk("perf_after", perf_issue_cnt, 11);
`endif

    // Reset asserted mid-cycle discards everything at once.
    grp(3, 91); step();
    clr_in();
    chk("pre_rst_free", 32'(free_count), 13);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_free", 32'(free_count), 16);
    chk("mid_rst_uop", 32'(uop_out), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
`ifdef IQ_PERF_CNT_EN
    chk("mid_rst_perf", perf_issue_cnt, 0);
`endif
    #2;
    reset_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(uop_out.valid), 0);
    chk("post_rst_free", 32'(free_count), 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
